// File: rtl/neocore_pkg.sv
// rtl/neocore_pkg.sv - NeoCore decode types, byte offsets and field helpers
package neocore_pkg;

  localparam int INST_BYTES = 13;
  localparam int INST_W     = 8 * INST_BYTES;

  // Byte offsets inside the left-aligned instruction
  localparam int OFF_SPEC = 0;
  localparam int OFF_OP   = 1;
  localparam int OFF_A    = 2;
  localparam int OFF_B    = 3;
  localparam int OFF_C    = 4;

  typedef enum logic [7:0] {
    OP_NOP   = 8'h00, OP_ADD   = 8'h01, OP_SUB = 8'h02, OP_MUL = 8'h03,
    OP_AND   = 8'h04, OP_OR    = 8'h05, OP_XOR = 8'h06, OP_LSH = 8'h07,
    OP_RSH   = 8'h08, OP_MOV   = 8'h09, OP_B   = 8'h0A, OP_BE  = 8'h0B,
    OP_BNE   = 8'h0C, OP_BLT   = 8'h0D, OP_BGT = 8'h0E, OP_BRO = 8'h0F,
    OP_UMULL = 8'h10, OP_SMULL = 8'h11, OP_HLT = 8'h12, OP_PSH = 8'h13,
    OP_POP   = 8'h14, OP_JSR   = 8'h15, OP_RTS = 8'h16
  } opcode_e;

  typedef enum logic [2:0] {
    ITYPE_CTRL = 3'd0, ITYPE_ALU, ITYPE_MOV, ITYPE_BRANCH,
    ITYPE_MUL, ITYPE_STACK, ITYPE_INVALID
  } itype_e;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0, ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_XOR,
    ALU_LSH, ALU_RSH, ALU_PASS, ALU_UMULL, ALU_SMULL
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0, MEM_HALF, MEM_WORD
  } mem_size_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [7:0]  specifier;
    itype_e      itype;
    alu_op_e     alu_op;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [3:0]  rd2;
    logic [31:0] imm;
    logic [31:0] mem_addr;
    logic [31:0] br_target;
    logic        rd_we;
    logic        rd2_we;
    logic        mem_read;
    logic        mem_write;
    mem_size_e   mem_size;
    logic        is_branch;
    logic        is_jsr;
    logic        is_rts;
    logic        is_halt;
  } decode_t;

  function automatic logic [7:0] inst_byte(input logic [INST_W-1:0] data, input int n);
    logic [INST_W-1:0] s;
    s = data << (8 * n);
    return s[INST_W-1 -: 8];
  endfunction

  // Big-endian 32-bit field starting at byte n
  function automatic logic [31:0] addr32(input logic [INST_W-1:0] data, input int n);
    logic [INST_W-1:0] s;
    s = data << (8 * n);
    return s[INST_W-1 -: 32];
  endfunction

  function automatic alu_op_e alu_of(input opcode_e op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_MUL:  return ALU_MUL;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_LSH:  return ALU_LSH;
      OP_RSH:  return ALU_RSH;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/neocore_decode_comb.sv
// rtl/neocore_decode_comb.sv - combinational field extractor (optional DECODE_LEN_CHECK_EN)
module neocore_decode_comb
  import neocore_pkg::*;
(
  input  logic [INST_W-1:0] inst_data,
  input  logic [3:0]        inst_len,
  output decode_t           dec
);

  logic [7:0] b0, b1, b2, b3;
  logic [3:0] arch_len;
  logic       ok;

  assign b0 = inst_byte(inst_data, OFF_SPEC);
  assign b1 = inst_byte(inst_data, OFF_OP);
  assign b2 = inst_byte(inst_data, OFF_A);
  assign b3 = inst_byte(inst_data, OFF_B);

`ifndef DECODE_LEN_CHECK_EN
  logic unused_len;
  assign unused_len = ^inst_len;
`endif

  // Decode opcode/specifier into fields; anything unrecognised collapses to INVALID
  always_comb begin
    dec      = '0;
    ok       = 1'b1;
    arch_len = 4'd0;
    case (opcode_e'(b1))
      OP_NOP, OP_HLT, OP_RTS: begin
        dec.itype   = ITYPE_CTRL;
        dec.is_halt = (b1 == OP_HLT);
        dec.is_rts  = (b1 == OP_RTS);
        arch_len    = 4'd2;
      end
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_LSH, OP_RSH: begin
        dec.itype  = ITYPE_ALU;
        dec.alu_op = alu_of(opcode_e'(b1));
        dec.rd     = b2[3:0];
        dec.rd_we  = 1'b1;
        case (b0)
          8'h00: begin
            dec.rs1  = b2[3:0];
            dec.imm  = {16'h0, b3, inst_byte(inst_data, OFF_C)};
            arch_len = 4'd5;
          end
          8'h01: begin
            dec.rs1  = b3[3:0];
            dec.rs2  = b2[3:0];
            arch_len = 4'd4;
          end
          8'h02: begin
            dec.rs1      = b2[3:0];
            dec.mem_addr = addr32(inst_data, OFF_B);
            dec.mem_read = 1'b1;
            dec.mem_size = MEM_WORD;
            arch_len     = 4'd7;
          end
          default: ok = 1'b0;
        endcase
      end
      OP_MOV: begin
        dec.itype  = ITYPE_MOV;
        dec.alu_op = ALU_PASS;
        dec.rd     = b2[3:0];
        arch_len   = 4'd7;
        case (b0)
          8'h00: begin
            dec.imm   = {16'h0, b3, inst_byte(inst_data, OFF_C)};
            dec.rd_we = 1'b1;
            arch_len  = 4'd5;
          end
          8'h01: begin
            dec.rs1   = b3[3:0];
            dec.rd_we = 1'b1;
            arch_len  = 4'd4;
          end
          8'h02, 8'h03, 8'h04: begin
            dec.mem_addr = addr32(inst_data, OFF_B);
            dec.mem_read = 1'b1;
            dec.rd_we    = 1'b1;
            dec.mem_size = (b0 == 8'h02) ? MEM_BYTE : (b0 == 8'h03) ? MEM_HALF : MEM_WORD;
          end
          8'h05, 8'h06, 8'h07: begin
            dec.mem_addr  = addr32(inst_data, OFF_B);
            dec.rs1       = b2[3:0];
            dec.mem_write = 1'b1;
            dec.mem_size  = (b0 == 8'h05) ? MEM_BYTE : (b0 == 8'h06) ? MEM_HALF : MEM_WORD;
          end
          default: ok = 1'b0;
        endcase
      end
      OP_B, OP_BRO: begin
        dec.itype     = ITYPE_BRANCH;
        dec.br_target = addr32(inst_data, OFF_A);
        dec.is_branch = 1'b1;
        arch_len      = 4'd6;
      end
      OP_BE, OP_BNE, OP_BLT, OP_BGT: begin
        dec.itype     = ITYPE_BRANCH;
        dec.rs1       = b2[3:0];
        dec.rs2       = b3[3:0];
        dec.br_target = addr32(inst_data, OFF_C);
        dec.is_branch = 1'b1;
        arch_len      = 4'd8;
      end
      OP_UMULL, OP_SMULL: begin
        dec.itype  = ITYPE_MUL;
        dec.alu_op = (b1 == OP_UMULL) ? ALU_UMULL : ALU_SMULL;
        dec.rd     = b2[3:0];
        dec.rd2    = b3[3:0];
        dec.rs1    = b2[3:0];
        dec.rs2    = inst_byte(inst_data, OFF_C) & 8'h0F;
        dec.rd_we  = 1'b1;
        dec.rd2_we = 1'b1;
        arch_len   = 4'd5;
      end
      OP_PSH: begin
        dec.itype = ITYPE_STACK;
        dec.rs1   = b2[3:0];
        arch_len  = 4'd3;
      end
      OP_POP: begin
        dec.itype = ITYPE_STACK;
        dec.rd    = b2[3:0];
        dec.rd_we = 1'b1;
        arch_len  = 4'd3;
      end
      OP_JSR: begin
        dec.itype     = ITYPE_CTRL;
        dec.br_target = addr32(inst_data, OFF_A);
        dec.is_jsr    = 1'b1;
        arch_len      = 4'd6;
      end
      default: ok = 1'b0;
    endcase
`ifdef DECODE_LEN_CHECK_EN
    if (inst_len != arch_len) ok = 1'b0;
`endif
    if (!ok) begin
      dec       = '0;
      dec.itype = ITYPE_INVALID;
    end
    dec.opcode    = opcode_e'(b1);
    dec.specifier = b0;
  end

endmodule

// File: rtl/neocore_decode_unit.sv
// rtl/neocore_decode_unit.sv - registered NeoCore decoder (optional DECODE_LEN_CHECK_EN)
module neocore_decode_unit
  import neocore_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst_data,
  input  logic [3:0]        inst_len,
  input  logic [31:0]       pc,
  input  logic              valid_in,
  output logic              valid_out,
  output opcode_e           opcode,
  output logic [7:0]        specifier,
  output itype_e            itype,
  output alu_op_e           alu_op,
  output logic [3:0]        rs1_addr,
  output logic [3:0]        rs2_addr,
  output logic [3:0]        rd_addr,
  output logic [3:0]        rd2_addr,
  output logic [31:0]       immediate,
  output logic [31:0]       mem_addr,
  output logic [31:0]       branch_target,
  output logic              rd_we,
  output logic              rd2_we,
  output logic              mem_read,
  output logic              mem_write,
  output mem_size_e         mem_size,
  output logic              is_branch,
  output logic              is_jsr,
  output logic              is_rts,
  output logic              is_halt
);

  decode_t dec;
  decode_t q;
  logic    valid_q;
  logic    unused_pc;

  assign unused_pc = ^pc;

  neocore_decode_comb u_comb (
    .inst_data (inst_data),
    .inst_len  (inst_len),
    .dec       (dec)
  );

  // Pipeline register; bubbles load all-zero so idle outputs are deterministic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else begin
      valid_q <= valid_in;
      q       <= valid_in ? dec : '0;
    end
  end

  assign valid_out     = valid_q;
  assign opcode        = q.opcode;
  assign specifier     = q.specifier;
  assign itype         = q.itype;
  assign alu_op        = q.alu_op;
  assign rs1_addr      = q.rs1;
  assign rs2_addr      = q.rs2;
  assign rd_addr       = q.rd;
  assign rd2_addr      = q.rd2;
  assign immediate     = q.imm;
  assign mem_addr      = q.mem_addr;
  assign branch_target = q.br_target;
  assign rd_we         = q.rd_we;
  assign rd2_we        = q.rd2_we;
  assign mem_read      = q.mem_read;
  assign mem_write     = q.mem_write;
  assign mem_size      = q.mem_size;
  assign is_branch     = q.is_branch;
  assign is_jsr        = q.is_jsr;
  assign is_rts        = q.is_rts;
  assign is_halt       = q.is_halt;

endmodule

// File: tb/tb_neocore_decode_unit.sv
// tb/tb_neocore_decode_unit.sv - self-checking bench for neocore_decode_unit
module tb_neocore_decode_unit;
  import neocore_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [103:0] inst_data;
  logic [3:0]   inst_len;
  logic [31:0]  pc;
  logic         valid_in;
  logic         valid_out;
  opcode_e      opcode;
  logic [7:0]   specifier;
  itype_e       itype;
  alu_op_e      alu_op;
  logic [3:0]   rs1_addr, rs2_addr, rd_addr, rd2_addr;
  logic [31:0]  immediate, mem_addr, branch_target;
  logic         rd_we, rd2_we, mem_read, mem_write;
  mem_size_e    mem_size;
  logic         is_branch, is_jsr, is_rts, is_halt;

  int n_checks = 0;
  int n_fail   = 0;

  decode_t obs;
  logic [8:0] strobes;

  always #5 clk = ~clk;

  neocore_decode_unit dut (
    .clk(clk), .rst(rst), .inst_data(inst_data), .inst_len(inst_len), .pc(pc),
    .valid_in(valid_in), .valid_out(valid_out), .opcode(opcode), .specifier(specifier),
    .itype(itype), .alu_op(alu_op), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd2_addr(rd2_addr), .immediate(immediate), .mem_addr(mem_addr),
    .branch_target(branch_target), .rd_we(rd_we), .rd2_we(rd2_we), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .is_branch(is_branch), .is_jsr(is_jsr),
    .is_rts(is_rts), .is_halt(is_halt)
  );

  // Gather the DUT outputs into one comparable bundle
  always_comb begin
    obs           = '0;
    obs.opcode    = opcode;
    obs.specifier = specifier;
    obs.itype     = itype;
    obs.alu_op    = alu_op;
    obs.rs1       = rs1_addr;
    obs.rs2       = rs2_addr;
    obs.rd        = rd_addr;
    obs.rd2       = rd2_addr;
    obs.imm       = immediate;
    obs.mem_addr  = mem_addr;
    obs.br_target = branch_target;
    obs.rd_we     = rd_we;
    obs.rd2_we    = rd2_we;
    obs.mem_read  = mem_read;
    obs.mem_write = mem_write;
    obs.mem_size  = mem_size;
    obs.is_branch = is_branch;
    obs.is_jsr    = is_jsr;
    obs.is_rts    = is_rts;
    obs.is_halt   = is_halt;
  end

  assign strobes = {valid_out, rd_we, rd2_we, mem_read, mem_write, is_branch, is_jsr, is_rts, is_halt};

  // Right-aligned n-byte literal moved to the left-aligned instruction bus
  function automatic logic [103:0] la(input logic [103:0] v, input int n);
    return v << (8 * (13 - n));
  endfunction

  // Reference decode built straight from the instruction table
  function automatic decode_t model(input logic [103:0] data, input int len, output int alen);
    logic [7:0] b[13];
    decode_t e;
    int op, sp;
    bit ok;
    for (int k = 0; k < 13; k++) b[k] = data[103 - 8 * k -: 8];
    e = '0; op = b[1]; sp = b[0]; ok = 1; alen = 0;
    if (op >= 1 && op <= 8) begin
      e.itype = ITYPE_ALU; e.alu_op = alu_op_e'(op); e.rd = b[2][3:0]; e.rd_we = 1;
      if (sp == 0) begin e.rs1 = b[2][3:0]; e.imm = {16'h0, b[3], b[4]}; alen = 5; end
      else if (sp == 1) begin e.rs1 = b[3][3:0]; e.rs2 = b[2][3:0]; alen = 4; end
      else if (sp == 2) begin
        e.rs1 = b[2][3:0]; e.mem_addr = {b[3], b[4], b[5], b[6]};
        e.mem_read = 1; e.mem_size = MEM_WORD; alen = 7;
      end else ok = 0;
    end else if (op == 9) begin
      e.itype = ITYPE_MOV; e.alu_op = ALU_PASS; e.rd = b[2][3:0];
      if (sp == 0) begin e.imm = {16'h0, b[3], b[4]}; e.rd_we = 1; alen = 5; end
      else if (sp == 1) begin e.rs1 = b[3][3:0]; e.rd_we = 1; alen = 4; end
      else if (sp >= 2 && sp <= 4) begin
        e.mem_addr = {b[3], b[4], b[5], b[6]}; e.mem_read = 1; e.rd_we = 1;
        e.mem_size = mem_size_e'(sp - 2); alen = 7;
      end else if (sp >= 5 && sp <= 7) begin
        e.mem_addr = {b[3], b[4], b[5], b[6]}; e.rs1 = b[2][3:0]; e.mem_write = 1;
        e.mem_size = mem_size_e'(sp - 5); alen = 7;
      end else ok = 0;
    end else if (op == 8'h0A || op == 8'h0F) begin
      e.itype = ITYPE_BRANCH; e.br_target = {b[2], b[3], b[4], b[5]}; e.is_branch = 1; alen = 6;
    end else if (op >= 8'h0B && op <= 8'h0E) begin
      e.itype = ITYPE_BRANCH; e.rs1 = b[2][3:0]; e.rs2 = b[3][3:0];
      e.br_target = {b[4], b[5], b[6], b[7]}; e.is_branch = 1; alen = 8;
    end else if (op == 8'h10 || op == 8'h11) begin
      e.itype = ITYPE_MUL; e.alu_op = (op == 8'h10) ? ALU_UMULL : ALU_SMULL;
      e.rd = b[2][3:0]; e.rd2 = b[3][3:0]; e.rs1 = b[2][3:0]; e.rs2 = b[4][3:0];
      e.rd_we = 1; e.rd2_we = 1; alen = 5;
    end else if (op == 8'h00) begin e.itype = ITYPE_CTRL; alen = 2;
    end else if (op == 8'h12) begin e.itype = ITYPE_CTRL; e.is_halt = 1; alen = 2;
    end else if (op == 8'h16) begin e.itype = ITYPE_CTRL; e.is_rts = 1; alen = 2;
    end else if (op == 8'h13) begin e.itype = ITYPE_STACK; e.rs1 = b[2][3:0]; alen = 3;
    end else if (op == 8'h14) begin e.itype = ITYPE_STACK; e.rd = b[2][3:0]; e.rd_we = 1; alen = 3;
    end else if (op == 8'h15) begin
      e.itype = ITYPE_CTRL; e.br_target = {b[2], b[3], b[4], b[5]}; e.is_jsr = 1; alen = 6;
    end else ok = 0;
`ifdef DECODE_LEN_CHECK_EN
    if (len != alen) ok = 0;
`else
    if (len < 0) ok = 0;
`endif
    if (!ok) begin e = '0; e.itype = ITYPE_INVALID; end
    e.opcode = opcode_e'(b[1]);
    e.specifier = b[0];
    return e;
  endfunction

  task automatic step(input logic [103:0] d, input int len, input bit v);
    @(negedge clk);
    inst_data = d; inst_len = len[3:0]; valid_in = v; pc = $urandom;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; inst_data = {$urandom, $urandom, $urandom, 8'hA5}; inst_len = 4'hF;
    pc = $urandom; valid_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", obs); end
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    valid_in = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (strobes !== '0) begin n_fail++; $display("FAIL idle_strobes: got %b want 0", strobes); end
  endtask

  task automatic test_alu;
    decode_t e; int al;
    step(la(104'h0001011234, 5), 5, 1);
    e = model(la(104'h0001011234, 5), 5, al);
    n_checks++;
    if ({valid_out, obs} !== {1'b1, e}) begin n_fail++; $display("FAIL add_imm: got %h want %h", {valid_out, obs}, {1'b1, e}); end
    n_checks++;
    if ({opcode, alu_op, rd_addr, rs1_addr, immediate, rd_we} !== {OP_ADD, ALU_ADD, 4'd1, 4'd1, 32'h1234, 1'b1}) begin
      n_fail++; $display("FAIL add_imm_fields: got rd=%0d rs1=%0d imm=%h we=%b", rd_addr, rs1_addr, immediate, rd_we);
    end
    step(la(104'h01010203, 4), 4, 1);
    e = model(la(104'h01010203, 4), 4, al);
    n_checks++;
    if ({valid_out, obs} !== {1'b1, e}) begin n_fail++; $display("FAIL add_reg: got %h want %h", {valid_out, obs}, {1'b1, e}); end
    n_checks++;
    if ({rd_addr, rs1_addr, rs2_addr} !== {4'd2, 4'd3, 4'd2}) begin
      n_fail++; $display("FAIL add_reg_fields: got rd=%0d rs1=%0d rs2=%0d want 2 3 2", rd_addr, rs1_addr, rs2_addr);
    end
  endtask

  task automatic test_mov;
    decode_t e; int al;
    step(la(104'h000905ABCD, 5), 5, 1);
    e = model(la(104'h000905ABCD, 5), 5, al);
    n_checks++;
    if ({valid_out, obs} !== {1'b1, e}) begin n_fail++; $display("FAIL mov_imm: got %h want %h", {valid_out, obs}, {1'b1, e}); end
    n_checks++;
    if ({itype, rd_addr, immediate, rd_we} !== {ITYPE_MOV, 4'd5, 32'hABCD, 1'b1}) begin
      n_fail++; $display("FAIL mov_imm_fields: got itype=%0d rd=%0d imm=%h we=%b", itype, rd_addr, immediate, rd_we);
    end
  endtask

  task automatic test_branch;
    decode_t e; int al;
    step(la(104'h000A12345678, 6), 6, 1);
    n_checks++;
    if ({is_branch, branch_target, itype} !== {1'b1, 32'h12345678, ITYPE_BRANCH}) begin
      n_fail++; $display("FAIL b_target: got br=%b tgt=%h want 1 12345678", is_branch, branch_target);
    end
    step(la(104'h000C0102ABCD0000, 8), 8, 1);
    e = model(la(104'h000C0102ABCD0000, 8), 8, al);
    n_checks++;
    if ({valid_out, obs} !== {1'b1, e}) begin n_fail++; $display("FAIL bne: got %h want %h", {valid_out, obs}, {1'b1, e}); end
    n_checks++;
    if ({rs1_addr, rs2_addr, branch_target} !== {4'd1, 4'd2, 32'hABCD0000}) begin
      n_fail++; $display("FAIL bne_fields: got rs1=%0d rs2=%0d tgt=%h", rs1_addr, rs2_addr, branch_target);
    end
  endtask

  task automatic test_mul_ctrl;
    step(la(104'h0010010203, 5), 5, 1);
    n_checks++;
    if ({itype, rd_addr, rd2_addr, rs2_addr, rd_we, rd2_we} !== {ITYPE_MUL, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL umull: got itype=%0d rd=%0d rd2=%0d rs2=%0d we=%b%b", itype, rd_addr, rd2_addr, rs2_addr, rd_we, rd2_we);
    end
    step(la(104'h0012, 2), 2, 1);
    n_checks++;
    if ({valid_out, is_halt, itype, rd_we, is_branch} !== {1'b1, 1'b1, ITYPE_CTRL, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL hlt: got v=%b halt=%b itype=%0d", valid_out, is_halt, itype);
    end
  endtask

  task automatic test_invalid;
    step(la(104'h00FF0102, 4), 4, 1);
    n_checks++;
    if ({valid_out, itype, strobes[7:0]} !== {1'b1, ITYPE_INVALID, 8'h00}) begin
      n_fail++; $display("FAIL invalid_op: got v=%b itype=%0d strobes=%b", valid_out, itype, strobes[7:0]);
    end
    step(la(104'h0901051234, 5), 5, 1);
    n_checks++;
    if ({itype, strobes[7:0]} !== {ITYPE_INVALID, 8'h00}) begin
      n_fail++; $display("FAIL invalid_spec: got itype=%0d strobes=%b", itype, strobes[7:0]);
    end
  endtask

  task automatic test_len_check;
    itype_e want;
`ifdef DECODE_LEN_CHECK_EN
    want = ITYPE_INVALID;
`else
    want = ITYPE_ALU;
`endif
    step(la(104'h0001011234, 5), 4, 1);
    n_checks++;
    if (itype !== want) begin n_fail++; $display("FAIL len_check: got itype=%0d want %0d", itype, want); end
  endtask

  task automatic test_back_to_back;
    decode_t e, pe;
    logic [103:0] d;
    int al, len, op, sp, r;
    bit v, pv, have;
    have = 0; pv = 0; pe = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (have) begin
        n_checks++;
        if (pv) begin
          if ({valid_out, obs} !== {1'b1, pe}) begin
            n_fail++; $display("FAIL rand_%0d: got %h want %h", i, {valid_out, obs}, {1'b1, pe});
          end
        end else if (strobes !== '0) begin
          n_fail++; $display("FAIL rand_idle_%0d: got %b want 0", i, strobes);
        end
      end
      r = $urandom_range(0, 24);
      op = (r <= 22) ? r : (r == 23) ? 8'hFF : $urandom_range(8'h17, 8'hFE);
      sp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 8);
      d = {$urandom, $urandom, $urandom, 8'($urandom)};
      d[103:88] = {8'(sp), 8'(op)};
      e = model(d, 0, al);
      len = ($urandom_range(0, 2) != 0 && al != 0) ? al : $urandom_range(2, 13);
      e = model(d, len, al);
      v = ($urandom_range(0, 4) != 0);
      inst_data = d; inst_len = len[3:0]; valid_in = v; pc = $urandom;
      pe = e; pv = v; have = 1;
    end
    @(negedge clk);
    n_checks++;
    if (pv ? ({valid_out, obs} !== {1'b1, pe}) : (strobes !== '0)) begin
      n_fail++; $display("FAIL rand_last: got %h want %h", {valid_out, obs}, {1'b1, pe});
    end
  endtask

  task automatic test_async_reset;
    step(la(104'h0012, 2), 2, 1);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({valid_out, obs} !== '0) begin n_fail++; $display("FAIL async_reset: got %h want 0", {valid_out, obs}); end
    @(negedge clk); rst = 1'b1; valid_in = 1'b0;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_mov;
    test_branch;
    test_mul_ctrl;
    test_invalid;
    test_len_check;
    test_back_to_back;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
